// File: rtl/dcache_pkg.sv
// Shared widths, state encoding and helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEF_LINES = 16;
    localparam int unsigned DEF_WORDS = 4;

    localparam int unsigned OFFSET_W  = 2;
    localparam int unsigned WORD_W    = $clog2(DEF_WORDS);
    localparam int unsigned INDEX_W   = $clog2(DEF_LINES);
    localparam int unsigned TAG_W     = ADDR_W - OFFSET_W - WORD_W - INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Tag width for an arbitrary geometry (the defaults above cover 16x4).
    function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
        return ADDR_W - OFFSET_W - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipeline-side access port and word-wide memory port of the data cache.
interface dcache_ctrl_if;

    logic        i_Rd_En;
    logic        i_Wr_En;
    logic [31:0] i_Addr;
    logic [31:0] i_Wr_Data;
    logic [31:0] o_Rd_Data;
    logic        o_DCache_Miss;
    logic        o_Mem_Req;
    logic        o_Mem_We;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_Wr_Data;
    logic [31:0] i_Mem_Rd_Data;
    logic        i_Mem_Ack;

    // Cache side.
    modport slave (
        input  i_Rd_En, i_Wr_En, i_Addr, i_Wr_Data, i_Mem_Rd_Data, i_Mem_Ack,
        output o_Rd_Data, o_DCache_Miss, o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wr_Data
    );

    // Pipeline + memory side.
    modport master (
        output i_Rd_En, i_Wr_En, i_Addr, i_Wr_Data, i_Mem_Rd_Data, i_Mem_Ack,
        input  o_Rd_Data, o_DCache_Miss, o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wr_Data
    );

endinterface

// File: rtl/dcache_tag_array.sv
// Valid + tag storage with combinational hit compare for one indexed line.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int unsigned LINES   = DEF_LINES,
    parameter int unsigned TAG_BITS = TAG_W
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic [$clog2(LINES)-1:0] index,
    input  logic [TAG_BITS-1:0]      tag,
    input  logic                     inv_en,
    input  logic                     wr_en,
    output logic                     hit
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];

    // Valid bits: set when a line fill completes, cleared when a fill starts.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[index] <= 1'b1;
        end else if (inv_en) begin
            valid_q[index] <= 1'b0;
        end
    end

    // Tag storage is not reset; it is only meaningful behind a valid bit.
    always_ff @(posedge i_Clk) begin
        if (wr_en) begin
            tag_q[index] <= tag;
        end
    end

    // Lookup for the currently addressed line.
    always_comb begin
        hit = valid_q[index] && (tag_q[index] == tag);
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = DEF_LINES,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    dcache_ctrl_if.slave  bus
);

    localparam int unsigned L_WORD_W  = $clog2(WORDS);
    localparam int unsigned L_INDEX_W = $clog2(LINES);
    localparam int unsigned L_TAG_W   = tag_width(LINES, WORDS);
    localparam logic [L_WORD_W-1:0] LAST_WORD = L_WORD_W'(WORDS - 1);

    state_t                state_q, state_d;
    logic [L_WORD_W-1:0]   cnt_q, cnt_d;

    logic [L_WORD_W-1:0]   word_sel;
    logic [L_INDEX_W-1:0]  index;
    logic [L_TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0]   unused_offset;

    logic                  hit;
    logic                  inv_en;
    logic                  tag_wr;
    logic                  refill_wr;
    logic                  store_wr;

    logic [DATA_W-1:0]     data_q [LINES][WORDS];

    assign word_sel      = bus.i_Addr[OFFSET_W +: L_WORD_W];
    assign index         = bus.i_Addr[OFFSET_W + L_WORD_W +: L_INDEX_W];
    assign tag           = bus.i_Addr[ADDR_W-1 -: L_TAG_W];
    assign unused_offset = bus.i_Addr[OFFSET_W-1:0];

    dcache_tag_array #(
        .LINES    (LINES),
        .TAG_BITS (L_TAG_W)
    ) u_tags (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .index  (index),
        .tag    (tag),
        .inv_en (inv_en),
        .wr_en  (tag_wr),
        .hit    (hit)
    );

    // State and refill word counter.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data array: refill words from memory, or update a resident line on a store ack.
    always_ff @(posedge i_Clk) begin
        if (refill_wr) begin
            data_q[index][cnt_q] <= bus.i_Mem_Rd_Data;
        end else if (store_wr) begin
            data_q[index][word_sel] <= bus.i_Wr_Data;
        end
    end

    // Next state, stall request and memory port drive.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        inv_en            = 1'b0;
        tag_wr            = 1'b0;
        refill_wr         = 1'b0;
        store_wr          = 1'b0;
        bus.o_Rd_Data     = '0;
        bus.o_DCache_Miss = 1'b0;
        bus.o_Mem_Req     = 1'b0;
        bus.o_Mem_We      = 1'b0;
        bus.o_Mem_Addr    = '0;
        bus.o_Mem_Wr_Data = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_Wr_En) begin
                    bus.o_DCache_Miss = 1'b1;
                    state_d           = ST_WRITE;
                end else if (bus.i_Rd_En) begin
                    if (hit) begin
                        bus.o_Rd_Data = data_q[index][word_sel];
                    end else begin
                        bus.o_DCache_Miss = 1'b1;
                        state_d           = ST_REFILL;
                        cnt_d             = '0;
                        inv_en            = 1'b1;
                    end
                end
            end
            ST_REFILL: begin
                bus.o_DCache_Miss = 1'b1;
                bus.o_Mem_Req     = 1'b1;
                bus.o_Mem_Addr    = {tag, index, cnt_q, 2'b00};
                if (bus.i_Mem_Ack) begin
                    refill_wr = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        tag_wr  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                bus.o_DCache_Miss = 1'b1;
                bus.o_Mem_Req     = 1'b1;
                bus.o_Mem_We      = 1'b1;
                bus.o_Mem_Addr    = {bus.i_Addr[ADDR_W-1:OFFSET_W], 2'b00};
                bus.o_Mem_Wr_Data = bus.i_Wr_Data;
                if (bus.i_Mem_Ack) begin
                    store_wr = hit;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed cases plus randomized loads/stores.
module tb_dcache_ctrl;

    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned LINE_BYTES = 4 * WORDS;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    logic clk;
    logic rst;

    dcache_ctrl_if bus ();

    dcache_ctrl #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mem_op_t      exp_mem[$];
    logic [31:0]  exp_rd[$];
    logic [31:0]  mem[logic [31:0]];

    bit           mvalid[LINES];
    int unsigned  mtag[LINES];
    int           lat_fixed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: decides ack per cycle, a fixed or random number of wait cycles.
    initial begin
        int wait_left;
        wait_left = -1;
        bus.i_Mem_Ack = 1'b0;
        bus.i_Mem_Rd_Data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !bus.o_Mem_Req) begin
                bus.i_Mem_Ack = 1'b0;
                bus.i_Mem_Rd_Data = '0;
                wait_left = -1;
            end else begin
                if (wait_left < 0)
                    wait_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                if (wait_left == 0) begin
                    bus.i_Mem_Ack = 1'b1;
                    if (bus.o_Mem_We) begin
                        mem[bus.o_Mem_Addr] = bus.o_Mem_Wr_Data;
                        bus.i_Mem_Rd_Data = '0;
                    end else begin
                        bus.i_Mem_Rd_Data = memval(bus.o_Mem_Addr);
                    end
                    wait_left = -1;
                end else begin
                    bus.i_Mem_Ack = 1'b0;
                    bus.i_Mem_Rd_Data = '0;
                    wait_left--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a memory word or a load.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.o_Mem_Req) begin
                chk("mem_idle_zero", {31'b0, bus.o_Mem_We} | bus.o_Mem_Addr | bus.o_Mem_Wr_Data, 32'h0);
            end else if (bus.i_Mem_Ack) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected", bus.o_Mem_Addr, 32'hFFFF_FFFF);
                end else begin
                    mem_op_t e;
                    e = exp_mem.pop_front();
                    chk("mem_we", {31'b0, bus.o_Mem_We}, {31'b0, e.we});
                    chk("mem_addr", bus.o_Mem_Addr, e.addr);
                    if (e.we) chk("mem_wdata", bus.o_Mem_Wr_Data, e.data);
                end
            end
            if (bus.i_Rd_En && !bus.o_DCache_Miss) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", bus.o_Rd_Data, 32'hFFFF_FFFF);
                end else begin
                    chk("rd_data", bus.o_Rd_Data, exp_rd.pop_front());
                end
            end
        end
    end

    // Issue one access, push its expected effects, and wait for the stall to drop.
    task automatic do_op(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                         output int mc, output bit exp_hit);
        int unsigned idx, tg;
        logic [31:0] wa, base;
        @(posedge clk);
        #1;
        wa   = a & ~32'h3;
        base = a & ~(LINE_BYTES - 1);
        idx  = (a / LINE_BYTES) % LINES;
        tg   = a / (LINE_BYTES * LINES);
        exp_hit = 1'b0;
        if (is_wr) begin
            exp_mem.push_back('{1'b1, wa, d});
        end else begin
            exp_hit = mvalid[idx] && (mtag[idx] == tg);
            if (!exp_hit) begin
                for (int unsigned k = 0; k < WORDS; k++)
                    exp_mem.push_back('{1'b0, base + 4 * k, 32'h0});
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
            end
            exp_rd.push_back(memval(wa));
        end
        bus.i_Addr    = a;
        bus.i_Wr_Data = d;
        bus.i_Wr_En   = is_wr;
        bus.i_Rd_En   = !is_wr;
        mc = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!bus.o_DCache_Miss) break;
            mc++;
        end
        if (mc >= 64) chk("stall_timeout", 32'(mc), 32'h0);
        if (is_wr) chk("done_no_req", {31'b0, bus.o_Mem_Req}, 32'h0);
        @(posedge clk);
        #1;
        bus.i_Rd_En = 1'b0;
        bus.i_Wr_En = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_miss"},  {31'b0, bus.o_DCache_Miss}, 32'h0);
        chk({nm, "_req"},   {31'b0, bus.o_Mem_Req}, 32'h0);
        chk({nm, "_we"},    {31'b0, bus.o_Mem_We}, 32'h0);
        chk({nm, "_addr"},  bus.o_Mem_Addr, 32'h0);
        chk({nm, "_wdata"}, bus.o_Mem_Wr_Data, 32'h0);
        chk({nm, "_rdata"}, bus.o_Rd_Data, 32'h0);
    endtask

    initial begin
        int mc;
        bit h;
        logic [31:0] a;

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mc;
        bit h;
        logic [31:0] a;

        rst = 1'b1;
        bus.i_Rd_En = 1'b0;
        bus.i_Wr_En = 1'b0;
        bus.i_Addr = '0;
        bus.i_Wr_Data = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            mvalid[i] = 1'b0;
            mtag[i] = 0;
        end
        mem[32'h40] = 32'h11;
        mem[32'h44] = 32'h22;
        mem[32'h48] = 32'h33;
        mem[32'h4C] = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        lat_fixed = 0;
        do_op(1'b0, 32'h40, 32'h0, mc, h);
        chk("cold_read_stall", 32'(mc), 32'(WORDS + 1));
        do_op(1'b0, 32'h48, 32'h0, mc, h);
        chk("hit_read_stall", 32'(mc), 32'h0);

        lat_fixed = 2;
        do_op(1'b1, 32'h44, 32'hDEAD_BEEF, mc, h);
        chk("store_hit_stall", 32'(mc), 32'h4);
        lat_fixed = 0;
        do_op(1'b0, 32'h44, 32'h0, mc, h);
        chk("read_after_store_stall", 32'(mc), 32'h0);

        do_op(1'b1, 32'h1000, 32'hCAFE_0001, mc, h);
        chk("store_miss_stall", 32'(mc), 32'h2);
        do_op(1'b0, 32'h1000, 32'h0, mc, h);
        chk("no_allocate_stall", 32'(mc), 32'(WORDS + 1));

        do_op(1'b0, 32'h440, 32'h0, mc, h);
        chk("conflict_stall", 32'(mc), 32'(WORDS + 1));
        do_op(1'b0, 32'h40, 32'h0, mc, h);
        chk("evicted_stall", 32'(mc), 32'(WORDS + 1));

        // Reset after the second refill ack of a load to 0x80.
        @(posedge clk);
        #1;
        exp_mem.push_back('{1'b0, 32'h80, 32'h0});
        exp_mem.push_back('{1'b0, 32'h84, 32'h0});
        bus.i_Addr  = 32'h80;
        bus.i_Rd_En = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_Rd_En = 1'b0;
        @(negedge clk);
        chk_outputs_zero("mid_refill_reset");
        chk("acks_before_reset", 32'(exp_mem.size()), 32'h0);
        exp_mem.delete();
        for (int unsigned i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(1'b0, 32'h80, 32'h0, mc, h);
        chk("refill_after_reset_stall", 32'(mc), 32'(WORDS + 1));

        lat_fixed = -1;
        for (int n = 0; n < 300; n++) begin
            bit wr;
            a  = ($urandom % 3) * (LINE_BYTES * LINES) + ($urandom % LINES) * LINE_BYTES
               + ($urandom % WORDS) * 4 + ($urandom % 4);
            wr = ($urandom % 10) < 4;
            do_op(wr, a, $urandom, mc, h);
            if (wr)
                chk("rand_store_stall", {31'b0, mc >= 2}, 32'h1);
            else if (h)
                chk("rand_hit_stall", 32'(mc), 32'h0);
            else
                chk("rand_miss_stall", {31'b0, mc >= int'(WORDS + 1)}, 32'h1);
        end

        repeat (3) @(posedge clk);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'h0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
